// File: rtl/ms_jk_flip_flop.sv
// Master-slave JK flip-flop bank: the master samples J/K on posedge, the slave copies it on negedge.
// Optional synchronous per-bit preset is enabled by defining MS_JK_PRESET_EN.
module ms_jk_flip_flop #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
`ifdef MS_JK_PRESET_EN
  input  logic [WIDTH-1:0] pre,
`endif
  output logic [WIDTH-1:0] qn,
  output logic [WIDTH-1:0] qn_bar,
  output logic [WIDTH-1:0] qm
);

  logic [WIDTH-1:0] r_master;
  logic [WIDTH-1:0] r_slave;
  logic             r_rst_pend;
  logic [WIDTH-1:0] w_master_d;
  logic [WIDTH-1:0] w_qn;
  logic [WIDTH-1:0] w_pre;

`ifdef MS_JK_PRESET_EN
  assign w_pre = pre;
`else
  assign w_pre = '0;
`endif

  always_comb begin
    w_master_d = r_master;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (rst) begin
        w_master_d[i] = 1'b0;
      end else if (w_pre[i]) begin
        w_master_d[i] = 1'b1;
      end else begin
        case ({s[i], r[i]})
          2'b00:   w_master_d[i] = w_qn[i];
          2'b01:   w_master_d[i] = 1'b0;
          2'b10:   w_master_d[i] = 1'b1;
          default: w_master_d[i] = ~w_qn[i];
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    r_master   <= w_master_d;
    r_rst_pend <= rst;
  end

  always_ff @(negedge clk) begin
    r_slave <= r_master;
  end

  // Reset must clear the slave on the posedge itself; masking the slave output until the next
  // negedge (when it reloads the cleared master) avoids a dual-edge register.
  assign w_qn   = r_rst_pend ? '0 : r_slave;
  assign qn     = w_qn;
  assign qn_bar = ~w_qn;
  assign qm     = r_master;

endmodule

// File: tb/tb_ms_jk_flip_flop.sv
// Bench for ms_jk_flip_flop: directed vector table on a 1-bit instance, random run on a 4-bit one.
module tb_ms_jk_flip_flop;

  logic       clk = 1'b0;
  logic       rst1, s1, r1, pre1;
  logic       qn1, qnb1, qm1;
  logic       rst4;
  logic [3:0] s4, r4, pre4;
  logic [3:0] qn4, qnb4, qm4;

  int total = 0;
  int bad   = 0;

  always #10 clk = ~clk;

  ms_jk_flip_flop #(.WIDTH(1)) dut1 (
    .clk    (clk),
    .rst    (rst1),
    .s      (s1),
    .r      (r1),
`ifdef MS_JK_PRESET_EN
    .pre    (pre1),
`endif
    .qn     (qn1),
    .qn_bar (qnb1),
    .qm     (qm1)
  );

  ms_jk_flip_flop #(.WIDTH(4)) dut4 (
    .clk    (clk),
    .rst    (rst4),
    .s      (s4),
    .r      (r4),
`ifdef MS_JK_PRESET_EN
    .pre    (pre4),
`endif
    .qn     (qn4),
    .qn_bar (qnb4),
    .qm     (qm4)
  );

  typedef struct {
    logic rst;
    logic pre;
    logic s;
    logic r;
    logic e_qm;
    logic e_qn_pos;
    logic e_qn_neg;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: characteristic equation Q+ = J&~Q | ~K&Q, preset forces 1, reset forces 0.
  function automatic logic [3:0] jk_next(input logic rst, input logic [3:0] pre,
                                         input logic [3:0] j, input logic [3:0] k,
                                         input logic [3:0] q);
    if (rst) return 4'b0;
    return pre | (j & ~q) | (~k & q);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before %0t", $time);
    $fatal(1);
  end

  initial begin
    logic [3:0] mq;
    logic [3:0] mm;
    logic [3:0] pre_r;

    //                rst pre s  r  qm qnP qnN
    tbl.push_back('{1, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{0, 0, 1, 0, 1, 0, 1});
    tbl.push_back('{0, 0, 0, 0, 1, 1, 1});
    tbl.push_back('{0, 0, 0, 0, 1, 1, 1});
    tbl.push_back('{0, 0, 0, 1, 0, 1, 0});
    tbl.push_back('{0, 0, 0, 1, 0, 0, 0});
    tbl.push_back('{0, 0, 1, 1, 1, 0, 1});
    tbl.push_back('{0, 0, 1, 1, 0, 1, 0});
    tbl.push_back('{0, 0, 1, 1, 1, 0, 1});
    tbl.push_back('{0, 0, 1, 1, 0, 1, 0});
    tbl.push_back('{0, 0, 1, 1, 1, 0, 1});
    tbl.push_back('{1, 0, 1, 1, 0, 0, 0});
    tbl.push_back('{1, 0, 1, 1, 0, 0, 0});
    tbl.push_back('{0, 0, 1, 1, 1, 0, 1});
`ifdef MS_JK_PRESET_EN
    tbl.push_back('{0, 1, 0, 1, 1, 1, 1});
    tbl.push_back('{0, 0, 0, 1, 0, 1, 0});
    tbl.push_back('{0, 1, 0, 1, 1, 0, 1});
    tbl.push_back('{1, 1, 0, 0, 0, 0, 0});
`endif

    rst4 = 1'b1; s4 = '0; r4 = '0; pre4 = '0;
    pre1 = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      rst1 = tbl[i].rst; pre1 = tbl[i].pre; s1 = tbl[i].s; r1 = tbl[i].r;
      @(posedge clk); #1;
      chk($sformatf("v%0d qm@pos", i), {3'b0, qm1}, {3'b0, tbl[i].e_qm});
      chk($sformatf("v%0d qn@pos", i), {3'b0, qn1}, {3'b0, tbl[i].e_qn_pos});
      @(negedge clk); #1;
      chk($sformatf("v%0d qn@neg", i), {3'b0, qn1}, {3'b0, tbl[i].e_qn_neg});
      chk($sformatf("v%0d qn_bar", i), {3'b0, qnb1}, {3'b0, ~tbl[i].e_qn_neg});
    end

    // Inputs changed between posedge and negedge must not affect that negedge.
    rst1 = 1'b1; pre1 = 1'b0; s1 = 1'b0; r1 = 1'b0;
    @(posedge clk); #1;
    @(negedge clk); #1;
    rst1 = 1'b0; s1 = 1'b1; r1 = 1'b0;
    @(posedge clk); #1;
    s1 = 1'b0; r1 = 1'b1;
    chk("late qn@pos", {3'b0, qn1}, 4'b0);
    @(negedge clk); #1;
    chk("late qn@neg", {3'b0, qn1}, 4'b1);
    chk("late qm@neg", {3'b0, qm1}, 4'b1);
    @(posedge clk); #1;
    chk("late qm next", {3'b0, qm1}, 4'b0);
    chk("late qn next", {3'b0, qn1}, 4'b1);
    @(negedge clk); #1;
    chk("late qn cleared", {3'b0, qn1}, 4'b0);

    // Random run on the 4-bit instance against the model.
    mq = 4'bxxxx;
    for (int n = 0; n < 300; n++) begin
      rst4 = (n == 0) || ($urandom_range(0, 15) == 0);
      s4   = 4'($urandom);
      r4   = 4'($urandom);
`ifdef MS_JK_PRESET_EN
      pre4 = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0;
`else
      pre4 = 4'b0;
`endif
      pre_r = pre4;
      mm = jk_next(rst4, pre_r, s4, r4, mq);
      @(posedge clk); #1;
      chk("rnd qm", qm4, mm);
      if (rst4) chk("rnd qn rst", qn4, 4'b0);
      else      chk("rnd qn hold", qn4, mq);
      @(negedge clk); #1;
      mq = mm;
      chk("rnd qn", qn4, mq);
      chk("rnd qn_bar", qnb4, ~mq);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
